// File: rtl/cmd_framer.sv
// Assembles 3-byte host command frames from the UART byte stream, echoes accepted bytes,
// and merges executor reply bytes onto the single transmit stream.
module cmd_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,

    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,

    output logic [1:0]  cmd_op,
    output logic [18:0] cmd_payload,
    output logic        cmd_valid,
    input  logic        cmd_ready,

    input  logic [7:0]  reply_data,
    input  logic        reply_valid,
    output logic        reply_ready,

    output logic        err_resync,
    output logic        err_timeout
);

    typedef enum logic [1:0] {StIdle, StGot1, StGot2, StHold} state_e;

    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]               hdr_q, hdr_d;
    logic [6:0]               b1_q, b1_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [1:0]               cmd_op_q, cmd_op_d;
    logic [18:0]              cmd_payload_q, cmd_payload_d;
    logic                     err_resync_q, err_resync_d;
    logic                     err_timeout_q, err_timeout_d;

    logic rx_fire;
    logic reply_fire;
    logic expired;

    // Reply bytes take the tx slot ahead of rx so the executor never stalls behind echoes.
    assign rx_ready    = !rst && !tx_valid_q && !reply_valid && (state_q != StHold);
    assign reply_ready = !rst && !tx_valid_q;
    assign rx_fire     = rx_valid && rx_ready;
    assign reply_fire  = reply_valid && reply_ready;
    assign expired     = TimeoutEn && (cnt_q == TimeoutLast);

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (reply_fire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = reply_data;
        end else if (rx_fire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = rx_data;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        hdr_d         = hdr_q;
        b1_d          = b1_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_op_d      = cmd_op_q;
        cmd_payload_d = cmd_payload_q;
        err_resync_d  = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    if (rx_data[7]) begin
                        hdr_d   = rx_data[6:0];
                        state_d = StGot1;
                    end else begin
                        err_resync_d = 1'b1;
                    end
                end
            end
            StGot1: begin
                if (rx_fire) begin
                    if (rx_data[7]) begin
                        hdr_d        = rx_data[6:0];
                        err_resync_d = 1'b1;
                    end else begin
                        b1_d    = rx_data[6:0];
                        state_d = StGot2;
                    end
                end else if (expired) begin
                    state_d       = StIdle;
                    err_timeout_d = 1'b1;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            StGot2: begin
                if (rx_fire) begin
                    if (rx_data[7]) begin
                        hdr_d        = rx_data[6:0];
                        err_resync_d = 1'b1;
                        state_d      = StGot1;
                    end else begin
                        cmd_valid_d   = 1'b1;
                        cmd_op_d      = hdr_q[6:5];
                        cmd_payload_d = {hdr_q[4:0], b1_q, rx_data[6:0]};
                        state_d       = StHold;
                    end
                end else if (expired) begin
                    state_d       = StIdle;
                    err_timeout_d = 1'b1;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            StHold: begin
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            hdr_q         <= '0;
            b1_q          <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_payload_q <= '0;
            err_resync_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hdr_q         <= hdr_d;
            b1_q          <= b1_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_op_q      <= cmd_op_d;
            cmd_payload_q <= cmd_payload_d;
            err_resync_q  <= err_resync_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_payload = cmd_payload_q;
    assign err_resync  = err_resync_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/cmd_framer.md
# cmd_framer

Byte-to-command framer between the UART receive/transmit stream and the board's command executor (transducer phase offsets, DAC divisor/value, reload, queries). It assembles 3-byte host frames, echoes every accepted byte back to the host, and recovers from dropped or garbled bytes by resynchronising on the header flag and timing out partial frames. It also arbitrates executor reply bytes (output count, version) onto the single transmit stream.

## Interface
- TIMEOUT_CYCLES, 50000: clock cycles allowed between bytes of one frame (1 ms at 50 MHz); 0 disables timeout
- TIMEOUT_WIDTH, 16: width of inter-byte counter; must hold TIMEOUT_CYCLES
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  framer accepts rx_data this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- cmd_op  out  2  opcode, header bits [6:5]
- cmd_payload  out  19  {hdr[4:0], b1[6:0], b2[6:0]}
- cmd_valid  out  1  frame complete, held until taken
- cmd_ready  in  1  executor takes frame
- reply_data  in  8  executor reply byte
- reply_valid  in  1  reply_data valid
- reply_ready  out  1  framer takes reply byte
- err_resync  out  1  one-cycle pulse: frame restarted or stray byte dropped
- err_timeout  out  1  one-cycle pulse: partial frame discarded by timeout

## Operation
- Frame: header byte (bit 7 = 1) then two data bytes (bit 7 = 0). Header bits [6:5] = opcode, [4:0] = high payload; data bytes carry 7 bits each.
- States: IDLE, GOT1, GOT2, HOLD.
- IDLE: accepted byte with bit7=1 → capture hdr, GOT1. bit7=0 → drop, pulse err_resync, stay.
- GOT1: bit7=0 → capture b1, GOT2. bit7=1 → capture as new hdr, stay GOT1, pulse err_resync.
- GOT2: bit7=0 → load cmd_op/cmd_payload, cmd_valid=1, HOLD. bit7=1 → new hdr, GOT1, pulse err_resync.
- HOLD: rx_ready=0; on cmd_valid && cmd_ready → cmd_valid=0, IDLE.
- Echo: every accepted byte (including dropped ones) is loaded into a single-entry tx register, tx_valid=1; cleared on tx_valid && tx_ready.
- rx_ready = !rst && !tx_valid && !reply_valid && state != HOLD.
- reply_ready = !rst && !tx_valid. Reply has priority over rx: when both valid and tx slot empty, reply byte is loaded, rx waits.
- Timeout: counter clears on every accepted byte; increments each cycle in GOT1/GOT2; on reaching TIMEOUT_CYCLES-1 → IDLE next cycle, pulse err_timeout. Byte acceptance in the same cycle as expiry wins (counter clears, no timeout). Counter held at 0 in IDLE/HOLD.
- cmd_op/cmd_payload stable while cmd_valid=1; retain last value otherwise.

## Timing
- Reset values: state IDLE, tx_valid 0, tx_data 0, cmd_valid 0, cmd_op 0, cmd_payload 0, err_resync 0, err_timeout 0, counter 0; rx_ready and reply_ready 0 while rst high.
- rst in mid-frame or HOLD discards the frame and any pending echo without emitting it.
- Byte accepted in cycle N → tx_valid=1 with same byte in N+1.
- Third byte accepted in cycle N → cmd_valid=1 in N+1; earliest next rx accept is N+2 after tx drains and executor takes cmd.
- cmd_ready sampled only while cmd_valid=1; consumption in cycle M → cmd_valid=0 in M+1, rx_ready may be 1 in M+1.
- err pulses are registered: asserted the cycle after the causing event, exactly one cycle.
- Throughput limited by single tx slot: one byte per echo completion.

## Test plan
- Frame 0x85,0x12,0x34 with tx_ready=1, cmd_ready=1 → echoes 0x85,0x12,0x34 in order; one cmd_valid pulse, cmd_op=0, cmd_payload={5'h05,7'h12,7'h34}.
- Stray 0x12 then frame 0xC8,0x01,0x7F → err_resync once, 0x12 echoed; cmd_op=2, cmd_payload={5'h08,7'h01,7'h7F}.
- 0xA0,0x05 then idle TIMEOUT_CYCLES (set 16) → err_timeout once, state IDLE; following 0x80,0x00,0x00 yields cmd_op=0, cmd_payload=0.
- cmd_ready=0 for 20 cycles after a complete frame → cmd_valid and payload stable, rx_ready=0 throughout; next frame accepted only after cmd_ready pulse.
- reply_valid with 0x58 asserted in the same cycle as rx_valid with 0x81 → 0x58 transmitted first, then echo of 0x81.
- rst pulsed after header and first data byte → all outputs at reset values next cycle; subsequent full frame decodes correctly.
